// File: rtl/postition_calc_if.sv
// postition_calc_if: pixel-position bus between a VGA raster source and postition_calc.
//   DrawX/DrawY    : current raster column/row (source -> calc)
//   posX/posY      : pixel offset from the play-area origin
//   tileX/tileY    : tile column/row index
//   relPos         : row-major pixel offset inside the tile
//   inArea         : pixel lies inside the play area
interface postition_calc_if;
  logic [9:0] DrawX, DrawY, posX, posY, relPos;
  logic [3:0] tileX, tileY;
  logic inArea;
  modport master(output DrawX, DrawY, input posX, posY, tileX, tileY, relPos, inArea);
  modport slave(input DrawX, DrawY, output posX, posY, tileX, tileY, relPos, inArea);
endinterface

// File: rtl/postition_calc.sv
// postition_calc: maps a VGA raster coordinate to play-area position, tile index and in-tile offset.
//   CLK     : clock, all state on rising edge
//   RESET_H : asynchronous active-high reset, clears all outputs immediately
//   bus     : slave side of postition_calc_if (DrawX/DrawY in, registered position outputs)
module postition_calc #(
  parameter logic [1:0][9:0] COOR = {10'd32, 10'd194},
  parameter logic [1:0][9:0] SIZE = {10'd352, 10'd352},
  parameter int TILE_WIDTH = 32
) (
  input logic CLK,
  input logic RESET_H,
  postition_calc_if.slave bus
);
  localparam int SH = $clog2(TILE_WIDTH);
  localparam logic [9:0] MASK = 10'(TILE_WIDTH - 1);
  // far edges held in 11 bits so origin+extent cannot wrap
  localparam logic [10:0] X_END = {1'b0, COOR[0]} + {1'b0, SIZE[0]};
  localparam logic [10:0] Y_END = {1'b0, COOR[1]} + {1'b0, SIZE[1]};
  logic in_area;
  logic [9:0] pos_x, pos_y;
  always_comb begin
    in_area = bus.DrawX >= COOR[0] && {1'b0, bus.DrawX} < X_END &&
              bus.DrawY >= COOR[1] && {1'b0, bus.DrawY} < Y_END;
    pos_x = bus.DrawX - COOR[0];
    pos_y = bus.DrawY - COOR[1];
  end
  always_ff @(posedge CLK or posedge RESET_H)
    if (RESET_H) begin
      bus.posX <= '0;
      bus.posY <= '0;
      bus.tileX <= '0;
      bus.tileY <= '0;
      bus.relPos <= '0;
      bus.inArea <= 1'b0;
    end else begin
      bus.posX <= in_area ? pos_x : '0;
      bus.posY <= in_area ? pos_y : '0;
      bus.tileX <= in_area ? 4'(pos_x >> SH) : '0;
      bus.tileY <= in_area ? 4'(pos_y >> SH) : '0;
      bus.relPos <= in_area ? ((pos_y & MASK) << SH) | (pos_x & MASK) : '0;
      bus.inArea <= in_area;
    end
endmodule

// File: tb/tb_postition_calc.sv
// tb_postition_calc: scoreboard bench for postition_calc with directed vectors, raster sweep and mid-stream reset.
module tb_postition_calc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  postition_calc_if bus();
  postition_calc dut(.CLK(clk), .RESET_H(rst), .bus(bus));
  typedef struct {
    string name;
    logic [9:0] px, py;
    logic [3:0] tx, ty;
    logic [9:0] rel;
    logic ia;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int tests = 0, fails = 0;
  int run = 0, max_run = 0, runs = 0;
  bit sweep_on = 0;
  function automatic exp_t mk(string n, int px, int py, int tx, int ty, int rel, bit ia);
    exp_t e;
    e.name = n; e.px = 10'(px); e.py = 10'(py); e.tx = 4'(tx); e.ty = 4'(ty);
    e.rel = 10'(rel); e.ia = ia;
    return e;
  endfunction
  function automatic exp_t model(string n, int x, int y);
    int px, py;
    if (!(x >= 194 && x < 546 && y >= 32 && y < 384)) return mk(n, 0, 0, 0, 0, 0, 0);
    px = x - 194;
    py = y - 32;
    return mk(n, px, py, px / 32, py / 32, (py % 32) * 32 + (px % 32), 1);
  endfunction
  task automatic check(string n, logic [10:0] a, logic [10:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic check_all(exp_t e);
    check({e.name, ".posX"}, {1'b0, bus.posX}, {1'b0, e.px});
    check({e.name, ".posY"}, {1'b0, bus.posY}, {1'b0, e.py});
    check({e.name, ".tileX"}, {7'd0, bus.tileX}, {7'd0, e.tx});
    check({e.name, ".tileY"}, {7'd0, bus.tileY}, {7'd0, e.ty});
    check({e.name, ".relPos"}, {1'b0, bus.relPos}, {1'b0, e.rel});
    check({e.name, ".inArea"}, {10'd0, bus.inArea}, {10'd0, e.ia});
  endtask
  task automatic drive(int x, int y, exp_t e);
    @(negedge clk);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      check_all(cur);
    end
    if (sweep_on) begin
      if (bus.inArea) run++;
      else begin
        if (run > 0) begin
          runs++;
          if (run > max_run) max_run = run;
        end
        run = 0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
  initial begin
    bus.DrawX = 10'd300;
    bus.DrawY = 10'd100;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_all(mk("reset", 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.DrawX = 10'd194;
    bus.DrawY = 10'd32;
    q.push_back(mk("origin", 0, 0, 0, 0, 0, 1));
    drive(226, 65, mk("tile11", 32, 33, 1, 1, 32, 1));
    drive(545, 383, mk("far_corner", 351, 351, 10, 10, 1023, 1));
    drive(193, 100, mk("left_out", 0, 0, 0, 0, 0, 0));
    drive(546, 100, mk("right_out", 0, 0, 0, 0, 0, 0));
    drive(300, 384, mk("bottom_out", 0, 0, 0, 0, 0, 0));
    drive(1023, 1023, mk("max_out", 0, 0, 0, 0, 0, 0));
    drive(194, 31, mk("top_out", 0, 0, 0, 0, 0, 0));
    drive(545, 32, mk("top_right", 351, 0, 10, 0, 31, 1));
    drive(194, 383, mk("bottom_left", 0, 351, 0, 10, 992, 1));
    drive(500, 1000, mk("y_high_out", 0, 0, 0, 0, 0, 0));
    drive(0, 40, mk("idle", 0, 0, 0, 0, 0, 0));
    sweep_on = 1;
    for (int x = 0; x < 640; x++) drive(x, 40, model("sweep", x, 40));
    drive(0, 40, model("tail", 0, 40));
    drive(0, 40, model("tail", 0, 40));
    @(posedge clk);
    #2 sweep_on = 0;
    check("sweep_runs", 11'(runs), 11'd1);
    check("sweep_run_len", 11'(max_run), 11'd352);
    for (int x = 280; x < 330; x++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.DrawX = 10'(x);
      bus.DrawY = 10'd40;
      if (x == 300) begin
        q.push_back(mk("rst_held", 0, 0, 0, 0, 0, 0));
        #2 rst = 1'b1;
        #1 check_all(mk("rst_async", 0, 0, 0, 0, 0, 0));
      end else q.push_back(model("resume", x, 40));
    end
    repeat (2) @(posedge clk);
    #2 check("queue_drain", 11'(q.size()), 11'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
